rect_matrix_mult: RTL
=====================

RECT_MATRIX_MULT -- requirements
Module: rect_matrix_mult

Interface
REQ-001 SHALL have parameter ROWS_A, default 4: rows of A and rows of C (M).
REQ-002 SHALL have parameter INNER, default 4: columns of A and rows of B (K).
REQ-003 SHALL have parameter COLS_B, default 4: columns of B and columns of C (N).
REQ-004 SHALL have parameter CELL_WIDTH, default 8: unsigned cell width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 8: register-file address width.
REQ-006 SHALL have parameter DATA_WIDTH, default INNER*CELL_WIDTH: row/column bus width.
REQ-007 SHALL have port in_clk, input, 1: the block's only clock, rising edge.
REQ-008 SHALL have port in_reset, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port in_ready, input, 1: start request.
REQ-010 SHALL have port in_mode, input, 1: 0 = C=A*B, 1 = C=C+A*B (accumulate); latched at start.
REQ-011 SHALL have port in_data, input, DATA_WIDTH: read data; cell 0 in the LSBs.
REQ-012 SHALL have port in_data_ready, input, 1: read data valid.
REQ-013 SHALL have port out_ack, input, 1: completion acknowledge.
REQ-014 SHALL have port out_reg_address, output, ADDR_WIDTH: read/write address.
REQ-015 SHALL have port out_type, output, 2: 00 cell, 01 row, 10 column.
REQ-016 SHALL have port out_matrix, output, 2: 00 A, 01 B, 10 C.
REQ-017 SHALL have ports out_read_en and out_write_en, output, 1 each: request strobes.
REQ-018 SHALL have port out_cell_c, output, CELL_WIDTH: C write data.
REQ-019 SHALL have ports out_busy and out_ready, output, 1 each: operation active; done.

Function
REQ-020 SHALL implement states IDLE, TAKEA, TAKEB, TAKEC, MAC, WRITE, DONE.
REQ-021 IDLE: on in_ready=1 SHALL latch in_mode, clear i=0 and j=0, and go to TAKEA; out_busy=1 in every state except IDLE and DONE.
REQ-022 TAKEA: SHALL hold out_read_en=1, out_matrix=00, out_type=01, address=i*INNER until in_data_ready=1, then capture the row and go to TAKEB.
REQ-023 TAKEB: SHALL hold out_read_en=1, out_matrix=01, out_type=10, address=j until in_data_ready=1, then capture the column and go to TAKEC if the latched mode=1, otherwise to MAC.
REQ-024 TAKEC: SHALL hold out_read_en=1, out_matrix=10, out_type=00, address=i*COLS_B+j until in_data_ready=1, then capture in_data[CELL_WIDTH-1:0] as the accumulator seed; in mode 0 the seed is 0.
REQ-025 Read strobes SHALL drop in the cycle after capture; in_data_ready outside TAKEA/TAKEB/TAKEC SHALL be ignored.
REQ-026 MAC: SHALL perform one multiply-accumulate per cycle over k=0..INNER-1, taking exactly INNER cycles.
REQ-027 Accumulator width SHALL be 2*CELL_WIDTH+$clog2(INNER)+1 so it never overflows internally.
REQ-028 WRITE: SHALL pulse out_write_en=1 for exactly one cycle with out_matrix=10, out_type=00, address=i*COLS_B+j and out_cell_c=result.
REQ-029 After WRITE: if j<COLS_B-1 then j++ and go to TAKEB (row of A reused); else if i<ROWS_A-1 then i++, j=0, go to TAKEA; else go to DONE.
REQ-030 DONE: SHALL hold out_ready=1 until out_ack=1, then go to IDLE with out_ready=0 on the next edge.
REQ-031 in_ready outside IDLE and out_ack outside DONE SHALL be ignored.
REQ-032 When not actively driven, address, type, matrix, strobes and out_cell_c SHALL be 0.

Reset
REQ-033 in_reset=0 SHALL immediately force state IDLE and all outputs, counters, captured operands and the accumulator to 0, including mid-operation; no partial write SHALL be issued afterwards.
REQ-034 After in_reset deasserts, the block SHALL accept in_ready on the first rising edge.

Configuration
REQ-035 With MATMUL_SATURATE_EN defined, a result exceeding 2^CELL_WIDTH-1 SHALL write 2^CELL_WIDTH-1; without it, the result SHALL be truncated to the low CELL_WIDTH bits (wrap).

Verification
REQ-036 M=2,K=3,N=2, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]], mode 0 -> writes 58@0, 64@1, 139@2, 154@3 in order, then out_ready=1.
REQ-037 Same operands, mode 1, C pre-filled with 1 -> TAKEC read before each MAC; writes 59, 65, 140, 155.
REQ-038 CELL_WIDTH=8, K=2, A row [200,200], B column [2,2] -> writes 255 with MATMUL_SATURATE_EN, 32 without.
REQ-039 in_data_ready delayed 5 cycles per read -> out_read_en held stable with address constant for all 5 cycles; results identical to REQ-036.
REQ-040 in_reset=0 during the MAC of C[1][0] -> all outputs 0 immediately, no further write; a fresh in_ready runs to completion correctly.
REQ-041 out_ack withheld 10 cycles -> out_ready stays 1 for those 10 cycles; in_ready pulses during busy -> no restart.

Source files
------------

// File: rtl/rect_matrix_mult_if.sv
// Request/response bundle between the matrix multiplier and its register file / controller.
// master = controller + register-file side, slave = rect_matrix_mult.
interface rect_matrix_mult_if #(
   parameter int CELL_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  in_ready;
   logic                  in_mode;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_data_ready;
   logic                  out_ack;
   logic [ADDR_WIDTH-1:0] out_reg_address;
   logic [1:0]            out_type;
   logic [1:0]            out_matrix;
   logic                  out_read_en;
   logic                  out_write_en;
   logic [CELL_WIDTH-1:0] out_cell_c;
   logic                  out_busy;
   logic                  out_ready;

   modport master (
      output in_ready, in_mode, in_data, in_data_ready, out_ack,
      input  out_reg_address, out_type, out_matrix, out_read_en, out_write_en,
             out_cell_c, out_busy, out_ready
   );

   modport slave (
      input  in_ready, in_mode, in_data, in_data_ready, out_ack,
      output out_reg_address, out_type, out_matrix, out_read_en, out_write_en,
             out_cell_c, out_busy, out_ready
   );
endinterface

// File: rtl/rect_matrix_mult.sv
// C = A*B (mode 0) or C = C + A*B (mode 1): reads a row of A, columns of B and optionally C cells, one MAC per cycle, one write per C cell.
// Define MATMUL_SATURATE_EN to clamp results to 2^CELL_WIDTH-1; otherwise results wrap to CELL_WIDTH bits.
module rect_matrix_mult #(
   parameter int ROWS_A     = 4,
   parameter int INNER      = 4,
   parameter int COLS_B     = 4,
   parameter int CELL_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = INNER * CELL_WIDTH
) (
   input  logic                    in_clk,
   input  logic                    in_reset,
   rect_matrix_mult_if.slave       bus
);

   localparam int ACC_W = 2 * CELL_WIDTH + $clog2(INNER) + 1;
   localparam int IW    = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
   localparam int JW    = (COLS_B > 1) ? $clog2(COLS_B) : 1;
   localparam int KW    = (INNER  > 1) ? $clog2(INNER)  : 1;

   typedef enum logic [2:0] {IDLE, TAKEA, TAKEB, TAKEC, MAC, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [IW-1:0]         i_q, i_d;
   logic [JW-1:0]         j_q, j_d;
   logic [KW-1:0]         k_q, k_d;
   logic [DATA_WIDTH-1:0] row_q, row_d;
   logic [DATA_WIDTH-1:0] col_q, col_d;
   logic [ACC_W-1:0]      acc_q, acc_d;

   logic [CELL_WIDTH-1:0]   cell_a, cell_b, result;
   logic [2*CELL_WIDTH-1:0] prod;
   logic [ADDR_WIDTH-1:0]   addr_a, addr_b, addr_c;

   logic [ADDR_WIDTH-1:0] reg_address;
   logic [1:0]            typ, matrix;
   logic                  read_en, write_en, busy, ready;
   logic [CELL_WIDTH-1:0] cell_c;

   assign cell_a = row_q[int'(k_q) * CELL_WIDTH +: CELL_WIDTH];
   assign cell_b = col_q[int'(k_q) * CELL_WIDTH +: CELL_WIDTH];
   assign prod   = {{CELL_WIDTH{1'b0}}, cell_a} * {{CELL_WIDTH{1'b0}}, cell_b};

   assign addr_a = ADDR_WIDTH'(int'(i_q) * INNER);
   assign addr_b = ADDR_WIDTH'(int'(j_q));
   assign addr_c = ADDR_WIDTH'(int'(i_q) * COLS_B + int'(j_q));

`ifdef MATMUL_SATURATE_EN
   localparam logic [ACC_W-1:0] CELL_MAX = {{(ACC_W-CELL_WIDTH){1'b0}}, {CELL_WIDTH{1'b1}}};
   assign result = (acc_q > CELL_MAX) ? {CELL_WIDTH{1'b1}} : acc_q[CELL_WIDTH-1:0];
`else
   assign result = acc_q[CELL_WIDTH-1:0];
`endif

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         row_q   <= row_d;
         col_q   <= col_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      row_d       = row_q;
      col_d       = col_q;
      acc_d       = acc_q;
      reg_address = '0;
      typ         = 2'b00;
      matrix      = 2'b00;
      read_en     = 1'b0;
      write_en    = 1'b0;
      busy        = 1'b0;
      ready       = 1'b0;
      cell_c      = '0;
      case (state_q)
         IDLE: begin
            if (bus.in_ready) begin
               mode_d  = bus.in_mode;
               i_d     = '0;
               j_d     = '0;
               state_d = TAKEA;
            end
         end
         TAKEA: begin
            busy        = 1'b1;
            read_en     = 1'b1;
            typ         = 2'b01;
            reg_address = addr_a;
            if (bus.in_data_ready) begin
               row_d   = bus.in_data;
               state_d = TAKEB;
            end
         end
         TAKEB: begin
            busy        = 1'b1;
            read_en     = 1'b1;
            matrix      = 2'b01;
            typ         = 2'b10;
            reg_address = addr_b;
            if (bus.in_data_ready) begin
               col_d   = bus.in_data;
               k_d     = '0;
               acc_d   = '0;
               state_d = mode_q ? TAKEC : MAC;
            end
         end
         TAKEC: begin
            busy        = 1'b1;
            read_en     = 1'b1;
            matrix      = 2'b10;
            reg_address = addr_c;
            if (bus.in_data_ready) begin
               acc_d   = ACC_W'(bus.in_data[CELL_WIDTH-1:0]);
               state_d = MAC;
            end
         end
         MAC: begin
            busy  = 1'b1;
            acc_d = acc_q + ACC_W'(prod);
            k_d   = k_q + 1'b1;
            if (k_q == KW'(INNER - 1)) state_d = WRITE;
         end
         WRITE: begin
            busy        = 1'b1;
            write_en    = 1'b1;
            matrix      = 2'b10;
            reg_address = addr_c;
            cell_c      = result;
            // Moving along a row keeps the captured A row; only a new row re-reads A.
            if (j_q != JW'(COLS_B - 1)) begin
               j_d     = j_q + 1'b1;
               state_d = TAKEB;
            end else if (i_q != IW'(ROWS_A - 1)) begin
               i_d     = i_q + 1'b1;
               j_d     = '0;
               state_d = TAKEA;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            ready = 1'b1;
            if (bus.out_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.out_reg_address = reg_address;
   assign bus.out_type        = typ;
   assign bus.out_matrix      = matrix;
   assign bus.out_read_en     = read_en;
   assign bus.out_write_en    = write_en;
   assign bus.out_cell_c      = cell_c;
   assign bus.out_busy        = busy;
   assign bus.out_ready       = ready;

endmodule
